// File: rtl/systolic_tile_sequencer.sv
// Sequences one matrix-multiply tile into a continuous_systolic array: accepts k_len A/B vectors,
// skews them into diagonal wavefronts, flushes the array and captures size result rows from c.
module systolic_tile_sequencer #(
  parameter int unsigned data_size   = 16,
  parameter int unsigned size        = 3,
  parameter int unsigned klen_w      = 8,
  parameter int unsigned drain_extra = 0,
  localparam int unsigned row_w      = (size > 1) ? $clog2(size) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [klen_w-1:0]         k_len,
  input  logic [data_size*size-1:0] a_vec,
  input  logic [data_size*size-1:0] b_vec,
  input  logic                      vec_valid,
  output logic                      vec_ready,
  output logic [data_size*size-1:0] sa_a,
  output logic [data_size*size-1:0] sa_b,
  output logic                      sa_reset_counter,
  input  logic [data_size*size-1:0] sa_c,
  output logic [data_size*size-1:0] c_out,
  output logic                      c_valid,
  output logic [row_w-1:0]          c_row,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned drain_len = 2 * size - 1 + drain_extra;
  localparam int unsigned cnt_max   = (drain_len > size) ? drain_len : size;
  localparam int unsigned ph_w      = $clog2(cnt_max + 1);
  localparam logic [ph_w-1:0] drain_last  = ph_w'(drain_len - 1);
  localparam logic [ph_w-1:0] result_last = ph_w'(size - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StResult, StDone} state_t;

  state_t              state_q;
  logic [klen_w-1:0]   rem_q;
  logic [ph_w-1:0]     phase_q;

  logic                     shift_en;
  logic                     take;
  logic [data_size*size-1:0] enter_a;
  logic [data_size*size-1:0] enter_b;

  assign shift_en = (state_q == StLoad) || (state_q == StDrain);
  assign take     = (state_q == StLoad) && vec_valid;
  // Bubbles and drain cycles push zeros so the array only ever accumulates real products.
  assign enter_a  = take ? a_vec : '0;
  assign enter_b  = take ? b_vec : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      rem_q            <= '0;
      phase_q          <= '0;
      vec_ready        <= 1'b0;
      sa_reset_counter <= 1'b0;
      c_out            <= '0;
      c_valid          <= 1'b0;
      c_row            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      sa_reset_counter <= 1'b0;
      done             <= 1'b0;
      c_valid          <= 1'b0;
      c_row            <= '0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (k_len != '0) begin
              state_q          <= StLoad;
              rem_q            <= k_len;
              vec_ready        <= 1'b1;
              sa_reset_counter <= 1'b1;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (vec_valid) begin
            rem_q <= rem_q - klen_w'(1);
            if (rem_q == klen_w'(1)) begin
              state_q   <= StDrain;
              vec_ready <= 1'b0;
              phase_q   <= '0;
            end
          end
        end
        StDrain: begin
          if (phase_q == drain_last) begin
            state_q <= StResult;
            phase_q <= '0;
            c_out   <= sa_c;
            c_valid <= 1'b1;
            c_row   <= '0;
          end else begin
            phase_q <= phase_q + ph_w'(1);
          end
        end
        StResult: begin
          if (phase_q == result_last) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            phase_q <= phase_q + ph_w'(1);
            c_out   <= sa_c;
            c_valid <= 1'b1;
            c_row   <= c_row + row_w'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar i = 0; i < size; i++) begin : g_lane
    logic [data_size-1:0] in_a;
    logic [data_size-1:0] in_b;
    assign in_a = enter_a[data_size*(size-i)-1 -: data_size];
    assign in_b = enter_b[data_size*(size-i)-1 -: data_size];

    if (i == 0) begin : g_pass
      assign sa_a[data_size*size-1 -: data_size] = in_a;
      assign sa_b[data_size*size-1 -: data_size] = in_b;
    end else begin : g_dly
      // Lane i needs i register stages to line up on the array diagonal.
      logic [data_size-1:0] a_q [i];
      logic [data_size-1:0] b_q [i];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d < i; d++) begin
            a_q[d] <= '0;
            b_q[d] <= '0;
          end
        end else if (shift_en) begin
          a_q[0] <= in_a;
          b_q[0] <= in_b;
          for (int d = 1; d < i; d++) begin
            a_q[d] <= a_q[d-1];
            b_q[d] <= b_q[d-1];
          end
        end else begin
          for (int d = 0; d < i; d++) begin
            a_q[d] <= '0;
            b_q[d] <= '0;
          end
        end
      end

      assign sa_a[data_size*(size-i)-1 -: data_size] = a_q[i-1];
      assign sa_b[data_size*(size-i)-1 -: data_size] = b_q[i-1];
    end
  end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: a timeline model predicts every output per cycle, and a
// lane-wise running-sum stand-in for the array supplies sa_c so captured rows are checkable.
module tb_systolic_tile_sequencer;
  localparam int DS   = 16;
  localparam int SZ   = 3;
  localparam int KW   = 8;
  localparam int W    = DS * SZ;
  localparam int MAXC = 1024;
  localparam int LAT  = 2 * SZ;    // last handshake -> first c_valid
  localparam int DOFF = LAT + SZ;  // last handshake -> done

  logic          clk = 1'b0;
  logic          reset, start, vec_valid, vec_ready, sa_reset_counter, c_valid, busy, done;
  logic [KW-1:0] k_len;
  logic [W-1:0]  a_vec, b_vec, sa_a, sa_b, sa_c, c_out;
  logic [1:0]    c_row;

  int cyc  = 0;
  int nvec = 0;
  int nerr = 0;

  bit [W-1:0] exp_a [MAXC];
  bit [W-1:0] exp_b [MAXC];
  bit [W-1:0] exp_cout [MAXC];
  bit [1:0]   exp_crow [MAXC];
  bit         exp_busy [MAXC];
  bit         exp_ready [MAXC];
  bit         exp_rc [MAXC];
  bit         exp_cvalid [MAXC];
  bit         exp_done [MAXC];

  logic [W-1:0] obs_a [MAXC];
  logic [W-1:0] obs_cout [MAXC];
  logic         obs_rc [MAXC];
  logic         obs_cvalid [MAXC];
  logic         obs_ready [MAXC];
  logic         obs_done [MAXC];

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic [W-1:0] acc = '0;

  systolic_tile_sequencer #(
    .data_size(DS), .size(SZ), .klen_w(KW), .drain_extra(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .a_vec(a_vec), .b_vec(b_vec),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .sa_a(sa_a), .sa_b(sa_b),
    .sa_reset_counter(sa_reset_counter), .sa_c(sa_c), .c_out(c_out), .c_valid(c_valid),
    .c_row(c_row), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DS-1:0] lane(input logic [W-1:0] v, input int i);
    return v[DS*(SZ-i)-1 -: DS];
  endfunction

  function automatic logic [W-1:0] lsum(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    for (int i = 0; i < SZ; i++) r[DS*(SZ-i)-1 -: DS] = DS'(lane(x, i) + lane(y, i));
    return r;
  endfunction

  function automatic logic [W-1:0] junk();
    return W'({$urandom, $urandom});
  endfunction

  // Stand-in array: each lane accumulates everything fed in since the last reset_counter.
  always @(posedge clk)
    acc <= sa_reset_counter ? lsum(sa_a, sa_b) : lsum(acc, lsum(sa_a, sa_b));
  assign sa_c = acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      obs_a[cyc]      = sa_a;
      obs_cout[cyc]   = c_out;
      obs_rc[cyc]     = sa_reset_counter;
      obs_cvalid[cyc] = c_valid;
      obs_ready[cyc]  = vec_ready;
      obs_done[cyc]   = done;
      chk("busy", 64'(busy), 64'(exp_busy[cyc]));
      chk("vec_ready", 64'(vec_ready), 64'(exp_ready[cyc]));
      chk("sa_reset_counter", 64'(sa_reset_counter), 64'(exp_rc[cyc]));
      chk("sa_a", 64'(sa_a), 64'(exp_a[cyc]));
      chk("sa_b", 64'(sa_b), 64'(exp_b[cyc]));
      chk("c_valid", 64'(c_valid), 64'(exp_cvalid[cyc]));
      chk("c_row", 64'(c_row), 64'(exp_crow[cyc]));
      chk("c_out", 64'(c_out), 64'(exp_cout[cyc]));
      chk("done", 64'(done), 64'(exp_done[cyc]));
    end
  end

  function automatic void put_vec(input int t, input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < SZ; i++) begin
      exp_a[t+i][DS*(SZ-i)-1 -: DS] = lane(a, i);
      exp_b[t+i][DS*(SZ-i)-1 -: DS] = lane(b, i);
    end
  endfunction

  function automatic void fill_cout(input int from, input logic [W-1:0] v);
    for (int c = from; c < MAXC; c++) exp_cout[c] = v;
  endfunction

  function automatic void clear_from(input int from);
    for (int c = from; c < MAXC; c++) begin
      exp_a[c] = '0; exp_b[c] = '0; exp_cout[c] = '0; exp_crow[c] = '0; exp_busy[c] = 0;
      exp_ready[c] = 0; exp_rc[c] = 0; exp_cvalid[c] = 0; exp_done[c] = 0;
    end
  endfunction

  function automatic int cnt(input int which, input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) begin
      case (which)
        0:       n += int'(obs_rc[c] === 1'b1);
        1:       n += int'(obs_cvalid[c] === 1'b1);
        default: n += int'(obs_ready[c] === 1'b1);
      endcase
    end
    return n;
  endfunction

  function automatic int first_cvalid(input int from);
    for (int c = from; c < MAXC; c++) if (obs_cvalid[c] === 1'b1) return c;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle; leaves in the first IDLE cycle after done.
  task automatic run_tile(input int k, input logic [15:0] stalls, input bit poke,
                          output int s, output int h);
    int n = 0;
    int j = 0;
    logic [W-1:0] sum = '0;
    s = cyc;
    start = 1'b1;
    k_len = KW'(k);
    if (k == 0) begin
      exp_busy[s+1] = 1;
      exp_done[s+1] = 1;
      vec_valid = 1'b1;
      a_vec = junk();
      tick();
      start = 1'b0;
      tick();
      vec_valid = 1'b0;
      h = s;
      return;
    end
    exp_rc[s+1] = 1;
    tick();
    start = 1'b0;
    while (n < k) begin
      exp_busy[cyc] = 1;
      exp_ready[cyc] = 1;
      if (stalls[j]) begin
        vec_valid = 1'b0;
        a_vec = junk();
        b_vec = junk();
      end else begin
        vec_valid = 1'b1;
        a_vec = va[n];
        b_vec = vb[n];
        put_vec(cyc, va[n], vb[n]);
        sum = lsum(sum, lsum(va[n], vb[n]));
        n++;
      end
      j++;
      tick();
    end
    h = cyc - 1;
    for (int c = h + 1; c <= h + DOFF; c++) exp_busy[c] = 1;
    for (int r = 0; r < SZ; r++) begin
      exp_cvalid[h+LAT+r] = 1;
      exp_crow[h+LAT+r] = 2'(r);
    end
    fill_cout(h + LAT, sum);
    exp_done[h+DOFF] = 1;
    for (int c = h + 1; c <= h + DOFF; c++) begin
      vec_valid = 1'b1;
      a_vec = junk();
      b_vec = junk();
      start = poke && (c == h + LAT + 1);
      k_len = 8'd1;
      tick();
    end
    vec_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic load_identity();
    va[0] = {16'h0100, 16'h0000, 16'h0000};
    va[1] = {16'h0000, 16'h0100, 16'h0000};
    va[2] = {16'h0000, 16'h0000, 16'h0100};
    vb[0] = {16'h0100, 16'h0200, 16'h0300};
    vb[1] = {16'h0400, 16'h0500, 16'h0600};
    vb[2] = {16'h0700, 16'h0800, 16'h0900};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int s, h, s3, h3, s4, h4, p1, p2;
    logic [15:0] stalls;
    reset = 1'b1; start = 1'b0; k_len = '0; vec_valid = 1'b0; a_vec = '0; b_vec = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // T1: reset two handshakes into a 3-vector load.
    load_identity();
    s = cyc;
    start = 1'b1;
    k_len = 8'd3;
    exp_rc[s+1] = 1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 2; n++) begin
      exp_busy[cyc] = 1;
      exp_ready[cyc] = 1;
      vec_valid = 1'b1;
      a_vec = va[n];
      b_vec = vb[n];
      put_vec(cyc, va[n], vb[n]);
      tick();
    end
    clear_from(cyc);
    reset = 1'b1;
    vec_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();

    // T2: skew of a single vector.
    va[0] = {16'h0100, 16'h0200, 16'h0300};
    vb[0] = '0;
    run_tile(1, 16'h0, 1'b0, s, h);
    chk("t2_skew_pre", 64'(obs_a[s]), 64'h0);
    chk("t2_skew_lane0", 64'(obs_a[s+1]), 64'h0100_0000_0000);
    chk("t2_skew_lane1", 64'(obs_a[s+2]), 64'h0000_0200_0000);
    chk("t2_skew_lane2", 64'(obs_a[s+3]), 64'h0000_0000_0300);
    chk("t2_skew_post", 64'(obs_a[s+4]), 64'h0);
    chk("t2_latency", 64'(first_cvalid(s) - h), 64'd6);
    chk("t2_c_out", 64'(obs_cout[h+6]), 64'h0100_0200_0300);
    repeat (2) tick();

    // T3: identity times B.
    load_identity();
    run_tile(3, 16'h0, 1'b0, s3, h3);
    chk("t3_c_out_row0", 64'(obs_cout[h3+6]), 64'h0D00_1000_1300);
    chk("t3_c_out_row2", 64'(obs_cout[h3+8]), 64'h0D00_1000_1300);
    chk("t3_rc_pulses", 64'(cnt(0, s3, cyc - 1)), 64'd1);
    chk("t3_c_valid_cycles", 64'(cnt(1, s3, cyc - 1)), 64'd3);

    // T4: same tile with two bubbles.
    p1 = $urandom_range(0, 3);
    p2 = (p1 + 1 + $urandom_range(0, 2)) % 4;
    stalls = 16'((1 << p1) | (1 << p2));
    run_tile(3, stalls, 1'b0, s4, h4);
    chk("t4_c_out", 64'(obs_cout[first_cvalid(s4)]), 64'h0D00_1000_1300);
    chk("t4_extra_delay", 64'((first_cvalid(s4) - s4) - (first_cvalid(s3) - s3)), 64'd2);

    // T5: empty tile.
    run_tile(0, 16'h0, 1'b0, s, h);
    chk("t5_done_cycle", 64'(obs_done[s+1]), 64'd1);
    chk("t5_quiet", 64'(cnt(0, s, s + 2) + cnt(1, s, s + 2) + cnt(2, s, s + 2)), 64'd0);

    // T6: start during RESULT ignored, then a tile right after done.
    load_identity();
    run_tile(3, 16'h0, 1'b1, s, h);
    chk("t6_first_rc", 64'(cnt(0, s, cyc - 1)), 64'd1);
    va[0] = {16'h0001, 16'h0002, 16'h0003};
    vb[0] = {16'h0010, 16'h0020, 16'h0030};
    va[1] = {16'hFFFF, 16'h0100, 16'h0000};
    vb[1] = {16'h0002, 16'h0000, 16'h0001};
    run_tile(2, 16'h0, 1'b0, s, h);
    chk("t6_second_rc", 64'(cnt(0, s, cyc - 1)), 64'd1);
    chk("t6_second_c_out", 64'(obs_cout[h+6]), 64'h0012_0122_0034);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
